// File: rtl/piso_shift_register_pkg.sv
// piso_shift_register_pkg: default geometry shared by the PISO shift register and its users.
package piso_shift_register_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in/serial-out shift register; in_si fills the vacated end for chaining.
module piso_shift_register
    import piso_shift_register_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = DEFAULT_MSB_FIRST
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_s,
    input  logic             in_si,
    input  logic [WIDTH-1:0] in_l,
    output logic             o_q
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;

    // Direction fixes both the shift expression and which end is tapped.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {sreg[WIDTH-2:0], in_si};
            assign o_q     = sreg[WIDTH-1];
        end else begin : g_lsb
            assign shifted = {in_si, sreg[WIDTH-1:1]};
            assign o_q     = sreg[0];
        end
    endgenerate

    always_ff @(posedge in_clk) begin
        if (in_rst)
            sreg <= '0;
        else
            sreg <= in_s ? shifted : in_l;
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: table-driven check of MSB-first and LSB-first instances sharing one stimulus.
module tb_piso_shift_register;

    logic       clk = 1'b0;
    logic       rst, s, si;
    logic [3:0] l;
    logic       q_msb, q_lsb;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .in_clk(clk), .in_rst(rst), .in_s(s), .in_si(si), .in_l(l), .o_q(q_msb)
    );

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .in_clk(clk), .in_rst(rst), .in_s(s), .in_si(si), .in_l(l), .o_q(q_lsb)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       s;
        logic       si;
        logic [3:0] l;
        logic       q_msb;
        logic [3:0] r_msb;
        logic       q_lsb;
        logic [3:0] r_lsb;
    } vec_t;

    vec_t vecs[$];

    task automatic step(input logic r, input logic sel, input logic sin, input logic [3:0] word);
        @(negedge clk);
        rst = r;
        s   = sel;
        si  = sin;
        l   = word;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; s = 1'b0; si = 1'b0; l = 4'b0000;
        //            name           rst  s    si   l        qM   rM       qL   rL
        vecs.push_back('{"rst_vs_load", 1, 0, 0, 4'b1111, 0, 4'b0000, 0, 4'b0000});
        vecs.push_back('{"load_1101",   0, 0, 0, 4'b1101, 1, 4'b1101, 1, 4'b1101});
        vecs.push_back('{"sh0_1",       0, 1, 0, 4'b0000, 1, 4'b1010, 0, 4'b0110});
        vecs.push_back('{"sh0_2",       0, 1, 0, 4'b0000, 0, 4'b0100, 1, 4'b0011});
        vecs.push_back('{"sh0_3",       0, 1, 0, 4'b0000, 1, 4'b1000, 1, 4'b0001});
        vecs.push_back('{"sh0_4",       0, 1, 0, 4'b0000, 0, 4'b0000, 0, 4'b0000});
        vecs.push_back('{"load_fill",   0, 0, 1, 4'b1101, 1, 4'b1101, 1, 4'b1101});
        vecs.push_back('{"sh1_1",       0, 1, 1, 4'b0000, 1, 4'b1011, 0, 4'b1110});
        vecs.push_back('{"sh1_2",       0, 1, 1, 4'b0000, 0, 4'b0111, 1, 4'b1111});
        vecs.push_back('{"sh1_3",       0, 1, 1, 4'b0000, 1, 4'b1111, 1, 4'b1111});
        vecs.push_back('{"sh1_4",       0, 1, 1, 4'b0000, 1, 4'b1111, 1, 4'b1111});
        vecs.push_back('{"sh1_past",    0, 1, 1, 4'b0000, 1, 4'b1111, 1, 4'b1111});
        vecs.push_back('{"load_mid",    0, 0, 0, 4'b1101, 1, 4'b1101, 1, 4'b1101});
        vecs.push_back('{"mid_sh1",     0, 1, 0, 4'b0000, 1, 4'b1010, 0, 4'b0110});
        vecs.push_back('{"mid_sh2",     0, 1, 0, 4'b0000, 0, 4'b0100, 1, 4'b0011});
        vecs.push_back('{"rst_mid",     1, 1, 1, 4'b1111, 0, 4'b0000, 0, 4'b0000});
        vecs.push_back('{"load_0110",   0, 0, 0, 4'b0110, 0, 4'b0110, 0, 4'b0110});
        vecs.push_back('{"sh_0110",     0, 1, 0, 4'b0000, 1, 4'b1100, 1, 4'b0011});
        vecs.push_back('{"reload_a",    0, 0, 0, 4'b1101, 1, 4'b1101, 1, 4'b1101});
        vecs.push_back('{"reload_sh",   0, 1, 0, 4'b0000, 1, 4'b1010, 0, 4'b0110});
        vecs.push_back('{"reload_b",    0, 0, 0, 4'b1000, 1, 4'b1000, 0, 4'b1000});
        vecs.push_back('{"idle_hold",   0, 0, 1, 4'b1000, 1, 4'b1000, 0, 4'b1000});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].s, vecs[i].si, vecs[i].l);
            check({vecs[i].name, ".q_msb"}, {3'b000, q_msb}, {3'b000, vecs[i].q_msb});
            check({vecs[i].name, ".r_msb"}, dut_msb.sreg, vecs[i].r_msb);
            check({vecs[i].name, ".q_lsb"}, {3'b000, q_lsb}, {3'b000, vecs[i].q_lsb});
            check({vecs[i].name, ".r_lsb"}, dut_lsb.sreg, vecs[i].r_lsb);
        end

        // Reset held over several edges with shift and all-ones fill must keep the register clear.
        step(0, 0, 0, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 1, 4'b1111);
            check("rst_hold.r_msb", dut_msb.sreg, 4'b0000);
            check("rst_hold.r_lsb", dut_lsb.sreg, 4'b0000);
        end

        // Serial chain pattern: after four shifts of 1,0,0,1 the register holds only in_si history.
        step(0, 0, 0, 4'b0110);
        step(0, 1, 1, 4'b0000);
        step(0, 1, 0, 4'b0000);
        step(0, 1, 0, 4'b0000);
        step(0, 1, 1, 4'b0000);
        check("hist.r_msb", dut_msb.sreg, 4'b1001);
        check("hist.r_lsb", dut_lsb.sreg, 4'b1001);
        check("hist.q_msb", {3'b000, q_msb}, 4'b0001);
        check("hist.q_lsb", {3'b000, q_lsb}, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
